// File: rtl/regfile_write_queue.sv
// In-order write-back buffer feeding the register file write port, with
// youngest-match read-after-write bypass on both regfile read addresses.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       rf_stall,
  output logic                       we3,
  output logic [AW-1:0]              wa3,
  output logic [XLEN-1:0]            wd3,
  input  logic [AW-1:0]              ra1,
  input  logic [AW-1:0]              ra2,
  output logic                       byp1_hit,
  output logic [XLEN-1:0]            byp1_data,
  output logic                       byp2_hit,
  output logic [XLEN-1:0]            byp2_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_reg;
  logic [AW-1:0]    addr_reg [DEPTH];
  logic [XLEN-1:0]  data_reg [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;

  logic accept;
  logic enq;
  logic pop;

  assign count    = count_reg;
  assign empty    = (count_reg == '0);
  assign in_ready = (count_reg < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  // Writes to x0 complete the handshake but are dropped.
  assign enq      = accept && (in_addr != '0);
  assign we3      = !empty && !rf_stall;
  assign pop      = we3;
  assign wa3      = empty ? '0 : addr_reg[head_reg];
  assign wd3      = empty ? '0 : data_reg[head_reg];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + PW'(1);
      end
      if (enq) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(enq) - CW'(pop);
    end
  end

  // Payload storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_reg[tail_reg] <= in_addr;
      data_reg[tail_reg] <= in_data;
    end
  end

  logic [AW-1:0]   ra_sel   [2];
  logic            hit_vec  [2];
  logic [XLEN-1:0] byp_data [2];

  assign ra_sel[0] = ra1;
  assign ra_sel[1] = ra2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_byp
      // Walk from head to tail so the youngest matching entry wins.
      always_comb begin
        logic [PW-1:0] idx;
        hit_vec[gi]  = 1'b0;
        byp_data[gi] = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_reg + PW'(k);
          if (valid_reg[idx] && (addr_reg[idx] == ra_sel[gi]) && (ra_sel[gi] != '0)) begin
            hit_vec[gi]  = 1'b1;
            byp_data[gi] = data_reg[idx];
          end
        end
      end
    end
  endgenerate

  assign byp1_hit  = hit_vec[0];
  assign byp1_data = byp_data[0];
  assign byp2_hit  = hit_vec[1];
  assign byp2_data = byp_data[1];

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed vector table plus randomized traffic against a queue-based model
// of the regfile write queue.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_addr;
  logic [XLEN-1:0] in_data;
  logic            rf_stall;
  logic            we3;
  logic [AW-1:0]   wa3;
  logic [XLEN-1:0] wd3;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic            byp1_hit;
  logic [XLEN-1:0] byp1_data;
  logic            byp2_hit;
  logic [XLEN-1:0] byp2_data;
  logic [CW-1:0]   count;
  logic            empty;

  regfile_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rf_stall  (rf_stall),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .byp1_hit  (byp1_hit),
    .byp1_data (byp1_data),
    .byp2_hit  (byp2_hit),
    .byp2_data (byp2_data),
    .count     (count),
    .empty     (empty)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        s;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        chk;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    int          e_cnt;
    logic        e_rdy;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic rst, input logic v, input logic [4:0] a, input logic [31:0] d,
    input logic s, input logic [4:0] r1, input logic [4:0] r2, input logic chk,
    input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
    input int e_cnt, input logic e_rdy, input logic e_h1, input logic [31:0] e_d1,
    input logic e_h2, input logic [31:0] e_d2);
    vec_t t;
    t.rst = rst; t.v = v; t.a = a; t.d = d; t.s = s; t.r1 = r1; t.r2 = r2;
    t.chk = chk; t.e_we = e_we; t.e_wa = e_wa; t.e_wd = e_wd; t.e_cnt = e_cnt;
    t.e_rdy = e_rdy; t.e_h1 = e_h1; t.e_d1 = e_d1; t.e_h2 = e_h2; t.e_d2 = e_d2;
    tbl.push_back(t);
  endfunction

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t model_q[$];

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_stall = 1'b0; ra1 = '0; ra2 = '0;

    // Reset held two cycles with a write to x3 pending on the input.
    add(1,1,3,32'h5,0, 3,0,0, 0,0,0,0,1, 0,0,0,0);
    add(1,1,3,32'h5,0, 3,0,1, 0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0,     3,0,1, 0,0,0,0,1, 0,0,0,0);
    // Single push, written at the next edge, bypassed while pending.
    add(0,1,5,32'hDEADBEEF,0, 5,0,1, 0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0, 5,0,1, 1,5,32'hDEADBEEF,1,1, 1,32'hDEADBEEF,0,0);
    add(0,0,0,0,0, 5,0,1, 0,0,0,0,1, 0,0,0,0);
    // Fill under stall, reject when full, drain in order.
    add(0,1,1,32'h11,1, 0,0,1, 0,0,0,0,1, 0,0,0,0);
    add(0,1,2,32'h22,1, 1,0,1, 0,1,32'h11,1,1, 1,32'h11,0,0);
    add(0,1,3,32'h33,1, 2,1,1, 0,1,32'h11,2,1, 1,32'h22,1,32'h11);
    add(0,1,4,32'h44,1, 3,0,1, 0,1,32'h11,3,1, 1,32'h33,0,0);
    add(0,1,6,32'h66,1, 6,4,1, 0,1,32'h11,4,0, 0,0,1,32'h44);
    add(0,0,0,0,0, 6,0,1, 1,1,32'h11,4,0, 0,0,0,0);
    add(0,0,0,0,0, 3,4,1, 1,2,32'h22,3,1, 1,32'h33,1,32'h44);
    add(0,0,0,0,0, 0,0,1, 1,3,32'h33,2,1, 0,0,0,0);
    add(0,0,0,0,0, 4,0,1, 1,4,32'h44,1,1, 1,32'h44,0,0);
    add(0,0,0,0,0, 6,0,1, 0,0,0,0,1, 0,0,0,0);
    // Same register twice: youngest bypassed, both committed in order.
    add(0,1,7,32'hA,1, 7,0,1, 0,0,0,0,1, 0,0,0,0);
    add(0,1,7,32'hB,1, 7,0,1, 0,7,32'hA,1,1, 1,32'hA,0,0);
    add(0,0,0,0,1, 7,0,1, 0,7,32'hA,2,1, 1,32'hB,0,0);
    add(0,0,0,0,0, 7,0,1, 1,7,32'hA,2,1, 1,32'hB,0,0);
    add(0,0,0,0,0, 7,7,1, 1,7,32'hB,1,1, 1,32'hB,1,32'hB);
    add(0,0,0,0,0, 7,0,1, 0,0,0,0,1, 0,0,0,0);
    // Write to x0 is dropped.
    add(0,1,0,32'hFFFFFFFF,0, 0,0,1, 0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0, 0,0,1, 0,0,0,0,1, 0,0,0,0);
    // Push and pop together at count 2.
    add(0,1,8,32'h80,1, 0,0,1, 0,0,0,0,1, 0,0,0,0);
    add(0,1,9,32'h90,1, 8,0,1, 0,8,32'h80,1,1, 1,32'h80,0,0);
    add(0,1,10,32'hA0,0, 9,0,1, 1,8,32'h80,2,1, 1,32'h90,0,0);
    add(0,0,0,0,1, 10,0,1, 0,9,32'h90,2,1, 1,32'hA0,0,0);
    // Count 3, stall released and reset in the same cycle.
    add(0,1,11,32'hB0,1, 0,0,1, 0,9,32'h90,2,1, 0,0,0,0);
    add(1,0,0,0,0, 11,0,1, 1,9,32'h90,3,1, 1,32'hB0,0,0);
    add(0,0,0,0,0, 11,0,1, 0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0, 9,0,1, 0,0,0,0,1, 0,0,0,0);

    @(posedge clock);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; in_valid = tbl[i].v; in_addr = tbl[i].a; in_data = tbl[i].d;
      rf_stall = tbl[i].s; ra1 = tbl[i].r1; ra2 = tbl[i].r2;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("row%0d we3", i), 32'(we3), 32'(tbl[i].e_we));
        check($sformatf("row%0d wa3", i), 32'(wa3), 32'(tbl[i].e_wa));
        check($sformatf("row%0d wd3", i), wd3, tbl[i].e_wd);
        check($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
        check($sformatf("row%0d empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
        check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
        check($sformatf("row%0d byp1_hit", i), 32'(byp1_hit), 32'(tbl[i].e_h1));
        check($sformatf("row%0d byp1_data", i), byp1_data, tbl[i].e_d1);
        check($sformatf("row%0d byp2_hit", i), 32'(byp2_hit), 32'(tbl[i].e_h2));
        check($sformatf("row%0d byp2_data", i), byp2_data, tbl[i].e_d2);
      end
      @(posedge clock);
      #1;
    end

    // Randomized traffic; the queue is empty and out of reset here.
    model_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic            m_we;
      logic [AW-1:0]   m_wa;
      logic [XLEN-1:0] m_wd;
      logic            m_rdy;
      logic            m_h1;
      logic            m_h2;
      logic [XLEN-1:0] m_d1;
      logic [XLEN-1:0] m_d2;

      reset    = ($urandom_range(0, 79) == 0);
      in_valid = ($urandom_range(0, 99) < 60);
      in_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 6));
      in_data  = $urandom;
      rf_stall = ($urandom_range(0, 99) < 45);
      ra1      = AW'($urandom_range(0, 6));
      ra2      = AW'($urandom_range(0, 6));
      #1;

      m_rdy = (model_q.size() < DEPTH);
      m_we  = (model_q.size() > 0) && !rf_stall;
      m_wa  = (model_q.size() > 0) ? model_q[0].addr : '0;
      m_wd  = (model_q.size() > 0) ? model_q[0].data : '0;
      m_h1 = 1'b0; m_d1 = '0; m_h2 = 1'b0; m_d2 = '0;
      for (int j = model_q.size() - 1; j >= 0; j--) begin
        if (!m_h1 && ra1 != 0 && model_q[j].addr == ra1) begin
          m_h1 = 1'b1; m_d1 = model_q[j].data;
        end
        if (!m_h2 && ra2 != 0 && model_q[j].addr == ra2) begin
          m_h2 = 1'b1; m_d2 = model_q[j].data;
        end
      end

      check($sformatf("rnd%0d we3", c), 32'(we3), 32'(m_we));
      check($sformatf("rnd%0d wa3", c), 32'(wa3), 32'(m_wa));
      check($sformatf("rnd%0d wd3", c), wd3, m_wd);
      check($sformatf("rnd%0d count", c), 32'(count), model_q.size());
      check($sformatf("rnd%0d empty", c), 32'(empty), 32'(model_q.size() == 0));
      check($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(m_rdy));
      check($sformatf("rnd%0d byp1", c), {31'(byp1_data), byp1_hit}, {31'(m_d1), m_h1});
      check($sformatf("rnd%0d byp1_data", c), byp1_data, m_d1);
      check($sformatf("rnd%0d byp2", c), {31'(byp2_data), byp2_hit}, {31'(m_d2), m_h2});
      check($sformatf("rnd%0d byp2_data", c), byp2_data, m_d2);

      @(posedge clock);
      if (reset) begin
        model_q.delete();
      end else begin
        ent_t e;
        if (m_we) void'(model_q.pop_front());
        if (in_valid && m_rdy && in_addr != 0) begin
          e.addr = in_addr;
          e.data = in_data;
          model_q.push_back(e);
        end
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Small in-order buffer directly upstream of the register file's write port (we3/wa3/wd3).
- Accepts register write-backs from multi-cycle producers (load unit, multiplier) through a valid/ready handshake.
- Drains one entry per cycle into the regfile; the drain can be held off by a stall.
- Provides read-after-write bypass on both regfile read addresses, so the operand read stage sees pending values before they are committed.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- XLEN, 32, data width; matches regfile wd3/rd1/rd2.
- AW, 5, register address width; matches ra1/ra2/wa3.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a write-back.
- in_ready  out  1  queue can accept an entry.
- in_addr  in  AW  destination register.
- in_data  in  XLEN  write-back value.
- rf_stall  in  1  high = hold off draining into regfile.
- we3  out  1  regfile write enable.
- wa3  out  AW  regfile write address.
- wd3  out  XLEN  regfile write data.
- ra1  in  AW  regfile read address 1 (snooped).
- ra2  in  AW  regfile read address 2 (snooped).
- byp1_hit  out  1  pending write matches ra1.
- byp1_data  out  XLEN  youngest pending value for ra1.
- byp2_hit  out  1  pending write matches ra2.
- byp2_data  out  XLEN  youngest pending value for ra2.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  count==0.

Behaviour:
- State: circular buffer of DEPTH {valid, addr, data} entries; head/tail pointers wrap modulo DEPTH; count register.
- Reset (synchronous, priority over push/pop):
  - Pointers, count and all valid bits are cleared; entry data is don't-care.
  - Outputs then read: in_ready=1, empty=1, count=0, we3=0, wa3=0, wd3=0, byp*_hit=0, byp*_data=0.
- Push:
  - in_ready = (count<DEPTH). It is a function of registered state only; no combinational path from rf_stall or in_valid.
  - An accept occurs at a rising edge when in_valid && in_ready.
  - If in_addr==0, the handshake completes but nothing is enqueued (x0 filter).
  - Otherwise the entry is written at tail, tail increments, and the entry is valid.
- Drain:
  - we3 = !empty && !rf_stall, combinational.
  - wa3/wd3 = head entry when !empty, else 0.
  - The regfile commits at the same rising edge. The head entry is popped at that edge (head increments, valid cleared).
- Latency:
  - An entry accepted at edge N is at head no earlier than after edge N.
  - With the queue empty and rf_stall low, it is written to the regfile at edge N+1.
  - There is no same-cycle pass-through.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- When full, in_ready=0 even if a pop occurs in the same cycle.
- Order: strict FIFO. Two writes to the same register commit in acceptance order.
- Bypass, per port (ra1 and ra2 independent, purely combinational):
  - hit = (ra!=0) and some valid entry has addr==ra.
  - data = value from the youngest matching entry (closest to tail), else 0.
  - The head entry being written this cycle still counts as a hit, because the regfile read this cycle returns the old value.
  - The incoming in_* in the same cycle is not bypassed.
- rf_stall high: no pops; pushes continue until full.
- Reset mid-drain: all pending entries are discarded and never written.
- Widths:
  - count never exceeds DEPTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
1. Hold reset 2 cycles with in_valid=1, in_addr=3, in_data=0x5 -> after release count=0, empty=1, in_ready=1, we3=0; no write of x3 ever appears.
2. rf_stall=0, push x5=0xDEADBEEF at edge N -> between N and N+1: we3=1, wa3=5, wd3=0xDEADBEEF, byp1_hit=1 when ra1=5 -> after N+1, empty=1.
3. rf_stall=1, push x1..x4 = 0x11,0x22,0x33,0x44 -> count=4, in_ready=0; then push x6=0x66 -> not accepted. Release stall -> we3=1 on 4 consecutive cycles with wa3 = 1,2,3,4 in order, then empty=1; x6 never written.
4. rf_stall=1, push x7=0xA then x7=0xB; ra1=7, ra2=0 -> byp1_hit=1, byp1_data=0xB, byp2_hit=0. Release stall -> x7 written 0xA then 0xB.
5. Push x0=0xFFFFFFFF -> handshake completes, count stays 0, we3 stays 0.
6. Two cases:
   - count=2, push and pop in same cycle -> count stays 2.
   - count=3, stall released and reset asserted the same cycle -> next cycle count=0, we3=0; no queued entry is written.
